// File: rtl/imowsum_pkg.sv
// Shared widths, divider timing and FSM encoding for the imowsum normalizer.
// Widths follow from a 91-tap window of 10-bit channels and Q1.8 weights.
package imowsum_pkg;
    localparam int DW_IN      = 10;
    localparam int DW_DEC     = 8;
    localparam int MAX_TAPS   = 91;
    localparam int NCH        = 4;
    localparam int TAP_W      = $clog2(MAX_TAPS);
    localparam int ACC_W      = DW_IN + TAP_W;
    localparam int WSUM_W     = DW_DEC + 1 + TAP_W;
    localparam int DIV_CYCLES = ACC_W + DW_DEC;
    localparam int DVD_W      = ACC_W + DW_DEC;
    localparam int DCNT_W     = $clog2(DIV_CYCLES);

    localparam logic [DVD_W:0] Q_MAX = (DVD_W+1)'((1 << DW_IN) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        RND  = 2'd2,
        HOLD = 2'd3
    } state_t;
endpackage

// File: rtl/imowsum_div.sv
// One channel's radix-2 restoring divider: quotient and remainder of dividend/divisor.
// Latency: DIV_CYCLES iterations after start; last_iter is high during the final one.
// Backpressure: none; the caller must hold divisor stable until last_iter.
module imowsum_div
    import imowsum_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DVD_W-1:0]  dividend,
    input  logic [WSUM_W-1:0] divisor,
    output logic [DVD_W-1:0]  quot,
    output logic [WSUM_W-1:0] rem,
    output logic              last_iter
);
    logic              active;
    logic [DCNT_W-1:0] cnt;
    logic [WSUM_W:0]   trial;
    logic [WSUM_W:0]   diff;

    // The dividend is shifted out of quot MSB-first while quotient bits shift in.
    assign trial     = {rem, quot[DVD_W-1]};
    assign diff      = trial - {1'b0, divisor};
    assign last_iter = active && (cnt == DCNT_W'(DIV_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
            quot   <= '0;
            rem    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            quot   <= dividend;
            rem    <= '0;
        end else if (active) begin
            cnt <= cnt + 1'b1;
            if (last_iter)
                active <= 1'b0;
            if (!diff[WSUM_W]) begin
                rem  <= diff[WSUM_W-1:0];
                quot <= {quot[DVD_W-2:0], 1'b1};
            end else begin
                rem  <= trial[WSUM_W-1:0];
                quot <= {quot[DVD_W-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/imowsum_normalize.sv
// Accumulates weighted taps over a mask window, divides each channel by the weight sum and rounds.
// Latency: out_vld rises 27 cycles after the last_tap cycle; the next window may accumulate meanwhile.
// Backpressure: result held until out_vld&out_rdy; a window ending while busy is dropped (sticky overrun).
// Optional tap-count checking is enabled with `define IMOWSUM_TAPCHK_EN.
module imowsum_normalize
    import imowsum_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tap_vld,
    input  logic                  first_tap,
    input  logic                  last_tap,
    input  logic [DW_DEC:0]       wtmp,
    input  logic [DW_IN*NCH-1:0]  imosum_part,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DW_IN*NCH-1:0]  imo_out,
    output logic                  busy,
    output logic                  overrun,
    output logic                  tap_err
);
    state_t state, state_n;

    logic [ACC_W-1:0]  acc_ch [NCH];
    logic [ACC_W-1:0]  sum_ch [NCH];
    logic [WSUM_W-1:0] acc_w, sum_w, wsum_q;
    logic [DVD_W-1:0]  quot   [NCH];
    logic [WSUM_W-1:0] rem    [NCH];
    logic [NCH-1:0]    div_last;
    logic [DVD_W:0]    q_rnd  [NCH];
    logic [DW_IN-1:0]  pix    [NCH];
    logic              win_end, accept_out, load;

    assign win_end    = tap_vld && last_tap;
    assign accept_out = (state == HOLD) && out_rdy;
    assign load       = win_end && ((state == IDLE) || accept_out);
    assign out_vld    = (state == HOLD);
    assign busy       = (state != IDLE);

    // Window sums including the current tap; first_tap discards the old accumulator.
    always_comb begin
        sum_w = (first_tap ? '0 : acc_w) + WSUM_W'(wtmp);
        for (int i = 0; i < NCH; i++)
            sum_ch[i] = (first_tap ? '0 : acc_ch[i])
                      + ACC_W'(imosum_part[(NCH-1-i)*DW_IN +: DW_IN]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_w <= '0;
            for (int i = 0; i < NCH; i++)
                acc_ch[i] <= '0;
        end else if (tap_vld) begin
            acc_w <= sum_w;
            for (int i = 0; i < NCH; i++)
                acc_ch[i] <= sum_ch[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wsum_q  <= '0;
            overrun <= 1'b0;
            imo_out <= '0;
        end else begin
            state <= state_n;
            if (load)
                wsum_q <= sum_w;
            if (win_end && !load)
                overrun <= 1'b1;
            if (state == RND)
                imo_out <= {pix[0], pix[1], pix[2], pix[3]};
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (load) state_n = DIV;
            DIV:  if (&div_last) state_n = RND;
            RND:  state_n = HOLD;
            HOLD: if (accept_out) state_n = load ? DIV : IDLE;
            default: state_n = IDLE;
        endcase
    end

    for (genvar g = 0; g < NCH; g++) begin : g_div
        imowsum_div u_div (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (load),
            .dividend  ({sum_ch[g], DW_DEC'(0)}),
            .divisor   (wsum_q),
            .quot      (quot[g]),
            .rem       (rem[g]),
            .last_iter (div_last[g])
        );
    end

    // Round half up, saturate to the channel range; an all-zero weight window yields black.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            q_rnd[i] = {1'b0, quot[i]} + (DVD_W+1)'({rem[i], 1'b0} >= {1'b0, wsum_q});
            if (wsum_q == '0)
                pix[i] = '0;
            else if (q_rnd[i] > Q_MAX)
                pix[i] = '1;
            else
                pix[i] = q_rnd[i][DW_IN-1:0];
        end
    end

`ifdef IMOWSUM_TAPCHK_EN
    localparam logic [TAP_W:0] MAX_CNT = (TAP_W+1)'(MAX_TAPS);
    localparam logic [TAP_W:0] SAT_CNT = (TAP_W+1)'(MAX_TAPS + 1);

    logic [TAP_W:0] tap_cnt, cnt_nxt;
    logic           win_open, err_q;

    assign cnt_nxt = first_tap ? (TAP_W+1)'(1)
                   : ((tap_cnt == SAT_CNT) ? tap_cnt : tap_cnt + 1'b1);
    assign tap_err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_cnt  <= '0;
            win_open <= 1'b0;
            err_q    <= 1'b0;
        end else if (tap_vld) begin
            tap_cnt  <= cnt_nxt;
            win_open <= (first_tap || win_open) && !last_tap;
            if ((first_tap && win_open) || (cnt_nxt > MAX_CNT)
                || (last_tap && (cnt_nxt != MAX_CNT)))
                err_q <= 1'b1;
        end
    end
`else
    assign tap_err = 1'b0;
`endif
endmodule

// File: tb/tb_imowsum_normalize.sv
// Self-checking bench for imowsum_normalize against an arithmetic model of window normalization.
`timescale 1ns/1ps
module tb_imowsum_normalize;
    localparam int MAXT = 91;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        tap_vld = 1'b0, first_tap = 1'b0, last_tap = 1'b0, out_rdy = 1'b0;
    logic [8:0]  wtmp = '0;
    logic [39:0] imosum_part = '0;
    logic        out_vld, busy, overrun, tap_err;
    logic [39:0] imo_out;

    int n_checks = 0, n_fail = 0;
    bit exp_err = 1'b0;
    int tw [MAXT];
    int tc [MAXT][4];
    int exp_pix [4];

    always #5 clk = ~clk;

    imowsum_normalize dut (
        .clk(clk), .rst_n(rst_n), .tap_vld(tap_vld), .first_tap(first_tap),
        .last_tap(last_tap), .wtmp(wtmp), .imosum_part(imosum_part),
        .out_vld(out_vld), .out_rdy(out_rdy), .imo_out(imo_out),
        .busy(busy), .overrun(overrun), .tap_err(tap_err)
    );

    // Nearest-integer of chsum/wsum in pixel units, half rounds up, saturating at 1023.
    function automatic int ref_pix(longint chsum, longint wsum);
        longint q;
        if (wsum == 0) return 0;
        q = (2 * chsum * 256 + wsum) / (2 * wsum);
        return (q > 1023) ? 1023 : int'(q);
    endfunction

    function automatic logic [39:0] exp_word();
        return {10'(exp_pix[0]), 10'(exp_pix[1]), 10'(exp_pix[2]), 10'(exp_pix[3])};
    endfunction

    task automatic fill_random(input int n, input int wmax);
        for (int i = 0; i < n; i++) begin
            tw[i] = $urandom_range(wmax, 0);
            for (int c = 0; c < 4; c++) begin
                tc[i][c] = ($urandom_range(1023, 0) * tw[i]) / 256;
                if (tc[i][c] > 1023) tc[i][c] = 1023;
            end
        end
    endtask

    task automatic send_window(input int n, input bit use_first, input int gap_max);
        longint cs [4];
        longint ws = 0;
        for (int c = 0; c < 4; c++) cs[c] = 0;
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    @(negedge clk);
                    tap_vld = 0; first_tap = 0; last_tap = 0;
                end
            end
            @(negedge clk);
            tap_vld     = 1;
            first_tap   = use_first && (i == 0);
            last_tap    = (i == n - 1);
            wtmp        = 9'(tw[i]);
            imosum_part = {10'(tc[i][0]), 10'(tc[i][1]), 10'(tc[i][2]), 10'(tc[i][3])};
            ws += tw[i];
            for (int c = 0; c < 4; c++) cs[c] += tc[i][c];
        end
        for (int c = 0; c < 4; c++) exp_pix[c] = ref_pix(cs[c], ws);
`ifdef IMOWSUM_TAPCHK_EN
        if (n != MAXT) exp_err = 1'b1;
`endif
    endtask

    // Cycles from the last_tap cycle until out_vld is seen; -1 if it never rises.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin tap_vld = 0; first_tap = 0; last_tap = 0; end
            if (out_vld) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_checks++; if (tap_err !== 1'b0) begin n_fail++; $display("FAIL reset_tap_err: got %b want 0", tap_err); end
        n_checks++; if (imo_out !== 40'h0) begin n_fail++; $display("FAIL reset_imo_out: got %h want 0", imo_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_window();
        int lat;
        for (int i = 0; i < MAXT; i++) begin
            tw[i] = 256;
            for (int c = 0; c < 4; c++) tc[i][c] = 500;
        end
        send_window(MAXT, 1'b1, 0);
        @(negedge clk); tap_vld = 0; first_tap = 0; last_tap = 0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b want 1", busy); end
        wait_result(lat);
        lat = lat + 1;
        n_checks++; if (lat !== 27) begin n_fail++; $display("FAIL full_latency: got %0d want 27", lat); end
        n_checks++; if (imo_out !== exp_word()) begin n_fail++; $display("FAIL full_imo_out: got %h want %h", imo_out, exp_word()); end
        out_rdy = 1; @(negedge clk); out_rdy = 0;
        n_checks++; if (out_vld !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_accept: got vld=%b busy=%b want 0 0", out_vld, busy); end
    endtask

    task automatic test_single_tap();
        int lat;
        tw[0] = 128;
        tc[0][0] = 250; tc[0][1] = 100; tc[0][2] = 0; tc[0][3] = 1023;
        send_window(1, 1'b1, 0);
        wait_result(lat);
        n_checks++; if (lat !== 27) begin n_fail++; $display("FAIL single_latency: got %0d want 27", lat); end
        n_checks++; if (imo_out !== exp_word()) begin n_fail++; $display("FAIL single_imo_out: got %h want %h", imo_out, exp_word()); end
        out_rdy = 1; @(negedge clk); out_rdy = 0;
    endtask

    task automatic test_zero_weight();
        int lat;
        fill_random(3, 0);
        for (int i = 0; i < 3; i++) tc[i][0] = $urandom_range(1023, 1);
        send_window(3, 1'b1, 0);
        wait_result(lat);
        n_checks++; if (lat !== 27) begin n_fail++; $display("FAIL zero_latency: got %0d want 27", lat); end
        n_checks++; if (imo_out !== exp_word()) begin n_fail++; $display("FAIL zero_imo_out: got %h want %h", imo_out, exp_word()); end
        out_rdy = 1; @(negedge clk); out_rdy = 0;
    endtask

    task automatic test_overrun();
        int lat;
        logic [39:0] first_res;
        fill_random(5, 300);
        send_window(5, 1'b1, 0);
        wait_result(lat);
        first_res = exp_word();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b want 0", overrun); end
        fill_random(4, 300);
        send_window(4, 1'b1, 1);
        @(negedge clk); tap_vld = 0; first_tap = 0; last_tap = 0;
        repeat (3) @(negedge clk);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
        n_checks++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL ovr_hold_vld: got %b want 1", out_vld); end
        n_checks++; if (imo_out !== first_res) begin n_fail++; $display("FAIL ovr_held_result: got %h want %h", imo_out, first_res); end
        out_rdy = 1; @(negedge clk); out_rdy = 0;
        n_checks++; if (out_vld !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got vld=%b busy=%b want 0 0", out_vld, busy); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid_divide();
        int lat;
        fill_random(20, 300);
        send_window(20, 1'b1, 0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin tap_vld = 0; first_tap = 0; last_tap = 0; end
        end
        rst_n = 1'b0;
        exp_err = 1'b0;
        #1;
        n_checks++; if (out_vld !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_state: got vld=%b busy=%b want 0 0", out_vld, busy); end
        n_checks++; if (overrun !== 1'b0 || tap_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: got ovr=%b err=%b want 0 0", overrun, tap_err); end
        @(negedge clk); rst_n = 1'b1;
        // No first_tap: the window must build on cleared accumulators.
        fill_random(MAXT, 300);
        send_window(MAXT, 1'b0, 0);
        wait_result(lat);
        n_checks++; if (lat !== 27) begin n_fail++; $display("FAIL rst_after_latency: got %0d want 27", lat); end
        n_checks++; if (imo_out !== exp_word()) begin n_fail++; $display("FAIL rst_after_imo_out: got %h want %h", imo_out, exp_word()); end
        out_rdy = 1; @(negedge clk); out_rdy = 0;
    endtask

    task automatic test_tap_count();
        int lat;
        fill_random(MAXT - 1, 256);
        send_window(MAXT - 1, 1'b1, 0);
        wait_result(lat);
        n_checks++; if (lat !== 27) begin n_fail++; $display("FAIL tapcnt_latency: got %0d want 27", lat); end
        n_checks++; if (imo_out !== exp_word()) begin n_fail++; $display("FAIL tapcnt_imo_out: got %h want %h", imo_out, exp_word()); end
        n_checks++; if (tap_err !== exp_err) begin n_fail++; $display("FAIL tapcnt_tap_err: got %b want %b", tap_err, exp_err); end
        out_rdy = 1; @(negedge clk); out_rdy = 0;
    endtask

    task automatic test_random();
        int lat, n;
        for (int w = 0; w < 6; w++) begin
            n = (w == 0) ? MAXT : $urandom_range(MAXT, 1);
            fill_random(n, 400);
            send_window(n, 1'b1, 2);
            wait_result(lat);
            n_checks++; if (lat !== 27) begin n_fail++; $display("FAIL rand%0d_latency: got %0d want 27", w, lat); end
            n_checks++; if (imo_out !== exp_word()) begin n_fail++; $display("FAIL rand%0d_imo_out: got %h want %h", w, imo_out, exp_word()); end
            n_checks++; if (tap_err !== exp_err || overrun !== 1'b0) begin n_fail++; $display("FAIL rand%0d_flags: got err=%b ovr=%b want %b 0", w, tap_err, overrun, exp_err); end
            repeat ($urandom_range(3, 0)) @(negedge clk);
            n_checks++; if (out_vld !== 1'b1 || imo_out !== exp_word()) begin n_fail++; $display("FAIL rand%0d_hold: got vld=%b %h want 1 %h", w, out_vld, imo_out, exp_word()); end
            out_rdy = 1; @(negedge clk); out_rdy = 0;
            n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL rand%0d_accept: got %b want 0", w, out_vld); end
        end
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_single_tap();
        test_zero_weight();
        test_overrun();
        test_reset_mid_divide();
        test_tap_count();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end
endmodule
